// File: rtl/mesi_isc_mbus_master.sv
// CPU-side main-bus initiator: executes one NOP/RD/WR instruction at a time on the
// main-bus RD/WR/ack protocol, captures read data and counts completed instructions.
module mesi_isc_mbus_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                tb_ins,
  input  logic [3:0]                tb_ins_addr,
  input  logic [7:0]                tb_ins_nop_period,
  input  logic [DATA_WIDTH-1:0]     tb_ins_data,
  output logic                      tb_ins_ack,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd,
  output logic [ADDR_WIDTH-1:0]     mbus_addr,
  output logic [DATA_WIDTH-1:0]     mbus_data_wr,
  input  logic                      mbus_ack,
  input  logic [DATA_WIDTH-1:0]     mbus_data_rd,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      illegal_err,
  output logic [31:0]               stat_rd,
  output logic [31:0]               stat_wr,
  output logic [31:0]               stat_nop
);

  localparam logic [3:0] INS_NOP = 4'd0;
  localparam logic [3:0] INS_WR  = 4'd1;
  localparam logic [3:0] INS_RD  = 4'd2;

  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP = MBUS_CMD_WIDTH'(0);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR  = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD  = MBUS_CMD_WIDTH'(2);

  // The wait counter reaches TIMEOUT on the edge where it currently holds TIMEOUT-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, NOP_WAIT, ACK} state_t;

  state_t      state, next_state;
  logic [15:0] cnt;
  logic        ins_bus, ins_nop, ack_hit, to_hit, nop_done;

  always_comb begin
    next_state = state;
    ins_bus    = (tb_ins == INS_RD) || (tb_ins == INS_WR);
    ins_nop    = (tb_ins == INS_NOP);
    ack_hit    = (state == REQ) && mbus_ack;
    to_hit     = (state == REQ) && !mbus_ack && (cnt == CNT_LAST);
    nop_done   = (state == NOP_WAIT) && (cnt == 16'd0);
    case (state)
      IDLE: begin
        if (ins_bus)      next_state = REQ;
        else if (ins_nop) next_state = NOP_WAIT;
        else              next_state = ACK;
      end
      REQ:      if (ack_hit || to_hit) next_state = ACK;
      NOP_WAIT: if (nop_done)          next_state = ACK;
      ACK:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      tb_ins_ack   <= 1'b0;
      mbus_cmd     <= CMD_NOP;
      mbus_addr    <= '0;
      mbus_data_wr <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      illegal_err  <= 1'b0;
      stat_rd      <= '0;
      stat_wr      <= '0;
      stat_nop     <= '0;
    end else begin
      tb_ins_ack <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (ins_bus) begin
            mbus_cmd  <= (tb_ins == INS_RD) ? CMD_RD : CMD_WR;
            mbus_addr <= ADDR_WIDTH'(tb_ins_addr);
            if (tb_ins == INS_WR) mbus_data_wr <= tb_ins_data;
            cnt <= '0;
          end else if (ins_nop) begin
            cnt <= 16'(tb_ins_nop_period);
          end else begin
            illegal_err <= 1'b1;
            tb_ins_ack  <= 1'b1;
          end
        end
        REQ: begin
          if (ack_hit || to_hit) begin
            // Aborted commands still count as completed instructions.
            mbus_cmd   <= CMD_NOP;
            tb_ins_ack <= 1'b1;
            if (mbus_cmd == CMD_RD) stat_rd <= stat_rd + 32'd1;
            else                    stat_wr <= stat_wr + 32'd1;
            if (ack_hit && (mbus_cmd == CMD_RD)) begin
              rd_data  <= mbus_data_rd;
              rd_valid <= 1'b1;
            end
            if (to_hit) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        NOP_WAIT: begin
          if (nop_done) begin
            tb_ins_ack <= 1'b1;
            stat_nop   <= stat_nop + 32'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_isc_mbus_master.sv
// Directed bench for mesi_isc_mbus_master: vector table of single instructions plus
// hand-written timeout, pulse-width and reset-abort sequences.
module tb_mesi_isc_mbus_master;

  localparam logic [3:0] INS_NOP = 4'd0;
  localparam logic [3:0] INS_WR  = 4'd1;
  localparam logic [3:0] INS_RD  = 4'd2;
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_WR  = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [3:0]  tb_ins = INS_NOP, tb_ins_addr = '0;
  logic [7:0]  tb_ins_nop_period = '0;
  logic [31:0] tb_ins_data = '0, mbus_data_rd = '0;
  logic        mbus_ack = 1'b0;
  logic        tb_ins_ack, rd_valid, busy, timeout_err, illegal_err;
  logic [2:0]  mbus_cmd;
  logic [31:0] mbus_addr, mbus_data_wr, rd_data, stat_rd, stat_wr, stat_nop;

  logic [3:0]  t_ins = INS_NOP, t_addr = '0;
  logic [7:0]  t_per = '0;
  logic [31:0] t_wdata = '0, t_rresp = '0;
  logic        t_mack = 1'b0;
  logic        t_ack, t_rdv, t_busy, t_to, t_ill;
  logic [2:0]  t_cmd;
  logic [31:0] t_maddr, t_mwdata, t_rd_data, t_srd, t_swr, t_snop;

  int tests = 0;
  int fails = 0;
  int cur_vec = -1;

  always #5 clk = ~clk;

  mesi_isc_mbus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MBUS_CMD_WIDTH(3), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .tb_ins(tb_ins), .tb_ins_addr(tb_ins_addr),
    .tb_ins_nop_period(tb_ins_nop_period), .tb_ins_data(tb_ins_data), .tb_ins_ack(tb_ins_ack),
    .mbus_cmd(mbus_cmd), .mbus_addr(mbus_addr), .mbus_data_wr(mbus_data_wr), .mbus_ack(mbus_ack),
    .mbus_data_rd(mbus_data_rd), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .timeout_err(timeout_err), .illegal_err(illegal_err),
    .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_nop(stat_nop));

  mesi_isc_mbus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MBUS_CMD_WIDTH(3), .TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .tb_ins(t_ins), .tb_ins_addr(t_addr),
    .tb_ins_nop_period(t_per), .tb_ins_data(t_wdata), .tb_ins_ack(t_ack),
    .mbus_cmd(t_cmd), .mbus_addr(t_maddr), .mbus_data_wr(t_mwdata), .mbus_ack(t_mack),
    .mbus_data_rd(t_rresp), .rd_data(t_rd_data), .rd_valid(t_rdv), .busy(t_busy),
    .timeout_err(t_to), .illegal_err(t_ill),
    .stat_rd(t_srd), .stat_wr(t_swr), .stat_nop(t_snop));

  typedef struct {
    logic [3:0]  ins;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  per;
    int          dly;     // cycles after the sample edge before mbus_ack; -1: stray ack held high
    logic [31:0] rresp;
    logic [2:0]  ecmd;
    int          eedges;  // edges from the sample edge to tb_ins_ack
    logic        erdv;
    logic [31:0] erd;
    logic [31:0] ewr;
    logic        eill;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, cur_vec, act, exp);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_cmd", 32'(mbus_cmd), 32'(CMD_NOP));
    chk("rst_addr", mbus_addr, 32'h0);
    chk("rst_wdata", mbus_data_wr, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_flags", {27'h0, tb_ins_ack, rd_valid, busy, timeout_err, illegal_err}, 32'h0);
    chk("rst_stats", stat_rd | stat_wr | stat_nop, 32'h0);
  endtask

  // Caller is either in the DUT's ACK cycle or just after reset release (DUT in IDLE).
  task automatic do_txn(input vec_t v);
    int k;
    tb_ins = v.ins; tb_ins_addr = v.addr; tb_ins_data = v.wdata; tb_ins_nop_period = v.per;
    mbus_data_rd = v.rresp;
    mbus_ack = (v.dly < 0);
    @(posedge clk); #1;
    if (!busy) begin
      @(posedge clk); #1;
    end
    chk("sample_cmd", 32'(mbus_cmd), 32'(v.ecmd));
    if (v.ecmd != CMD_NOP) chk("sample_addr", mbus_addr, 32'(v.addr));
    k = 0;
    while (!tb_ins_ack && k < 40) begin
      if (k == v.dly) mbus_ack = 1'b1;
      @(posedge clk); #1;
      k++;
      if (!tb_ins_ack) begin
        chk("hold_cmd", 32'(mbus_cmd), 32'(v.ecmd));
        chk("hold_rdv", 32'(rd_valid), 32'h0);
        if (v.ecmd != CMD_NOP) begin
          chk("hold_addr", mbus_addr, 32'(v.addr));
          chk("hold_wdata", mbus_data_wr, v.ewr);
        end
      end
    end
    mbus_ack = 1'b0;
    chk("ack_edges", 32'(k), 32'(v.eedges));
    chk("ack_seen", 32'(tb_ins_ack), 32'h1);
    chk("done_cmd", 32'(mbus_cmd), 32'(CMD_NOP));
    chk("done_rdv", 32'(rd_valid), 32'(v.erdv));
    chk("done_rd_data", rd_data, v.erd);
    chk("done_wdata", mbus_data_wr, v.ewr);
    chk("done_illegal", 32'(illegal_err), 32'(v.eill));
    chk("done_busy", 32'(busy), 32'h1);
  endtask

  initial begin
    int edges, cmd_cycles, rdv_seen;
    vec_t rv;

    vecs[0] = '{INS_RD,  4'h3, 32'h0,         8'd0, 0,  32'hA5A5_0001, CMD_RD,  1, 1'b1, 32'hA5A5_0001, 32'h0,         1'b0};
    vecs[1] = '{INS_WR,  4'h9, 32'h0000_00FF, 8'd0, 5,  32'h1111_1111, CMD_WR,  6, 1'b0, 32'hA5A5_0001, 32'h0000_00FF, 1'b0};
    vecs[2] = '{INS_NOP, 4'h0, 32'h0,         8'd0, -1, 32'hBBBB_0002, CMD_NOP, 1, 1'b0, 32'hA5A5_0001, 32'h0000_00FF, 1'b0};
    vecs[3] = '{INS_NOP, 4'h0, 32'h0,         8'd7, -1, 32'hCCCC_0003, CMD_NOP, 8, 1'b0, 32'hA5A5_0001, 32'h0000_00FF, 1'b0};
    vecs[4] = '{INS_RD,  4'hF, 32'h7777_7777, 8'd0, 2,  32'h1234_5678, CMD_RD,  3, 1'b1, 32'h1234_5678, 32'h0000_00FF, 1'b0};
    vecs[5] = '{INS_WR,  4'h0, 32'hDEAD_BEEF, 8'd0, 0,  32'h9999_9999, CMD_WR,  1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{4'hF,    4'h7, 32'h0,         8'd0, -1, 32'hEEEE_0004, CMD_NOP, 0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};

    // Timeout instance: RD with no responder.
    t_ins = INS_RD; t_addr = 4'h2;
    tb_ins = INS_NOP; tb_ins_nop_period = 8'd255;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b1;
    edges = 0; cmd_cycles = 0; rdv_seen = 0;
    while (!t_ack && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (t_cmd == CMD_RD) cmd_cycles++;
      if (t_rdv) rdv_seen = 1;
    end
    chk("to_edges", 32'(edges), 32'd5);
    chk("to_cmd_cycles", 32'(cmd_cycles), 32'd4);
    chk("to_no_rdv", 32'(rdv_seen), 32'h0);
    chk("to_cmd_dropped", 32'(t_cmd), 32'(CMD_NOP));
    chk("to_err", 32'(t_to), 32'h1);
    chk("to_stat_rd", t_srd, 32'd1);
    chk("to_rd_data", t_rd_data, 32'h0);
    t_ins = INS_NOP; t_per = 8'd255;
    @(posedge clk); #1;
    chk("to_ack_pulse", 32'(t_ack), 32'h0);
    chk("to_err_sticky", 32'(t_to), 32'h1);

    // Main instance: vector table.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state();
    chk("to_err_cleared", 32'(t_to), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      do_txn(vecs[i]);
    end
    cur_vec = -1;
    chk("stat_rd", stat_rd, 32'd2);
    chk("stat_wr", stat_wr, 32'd2);
    chk("stat_nop", stat_nop, 32'd2);

    // Reset in the middle of a pending RD.
    tb_ins = INS_RD; tb_ins_addr = 4'h5; tb_ins_nop_period = 8'd0;
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(tb_ins_ack), 32'h0);
    if (!busy) begin
      @(posedge clk); #1;
    end
    chk("mid_cmd", 32'(mbus_cmd), 32'(CMD_RD));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_state();
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_ack", 32'(tb_ins_ack), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    rv = '{INS_RD, 4'h6, 32'h0, 8'd0, 1, 32'h0BAD_F00D, CMD_RD, 2, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0};
    cur_vec = 7;
    do_txn(rv);
    chk("post_rst_stat_rd", stat_rd, 32'd1);
    chk("post_rst_stat_wr", stat_wr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
